// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU.
// Opcode encodings for the arithmetic/logic and shift groups.
package alu_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_SLT   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam logic [2:0] SH_SLL = 3'b000;
  localparam logic [2:0] SH_SRL = 3'b001;
  localparam logic [2:0] SH_SRA = 3'b010;
  localparam logic [2:0] SH_ROL = 3'b011;
  localparam logic [2:0] SH_ROR = 3'b100;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 4-stage barrel shifter.
// Each stage moves the value by 1, 2, 4 or 8 bits when its sh bit is set.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [3:0]   i_sh,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_y
);

  function automatic logic [W-1:0] stage(
    input logic [W-1:0] a,
    input logic [2:0]   op,
    input int unsigned  d
  );
    logic [W-1:0] r;
    case (op)
      SH_SLL:  r = a << d;
      SH_SRL:  r = a >> d;
      SH_SRA:  r = $signed(a) >>> d;
      SH_ROL:  r = (a << d) | (a >> (W - d));
      SH_ROR:  r = (a >> d) | (a << (W - d));
      default: r = a;
    endcase
    return r;
  endfunction

  logic [W-1:0] w_stg [5];

  assign w_stg[0] = i_a;

  for (genvar k = 0; k < 4; k++) begin : g_stage
    localparam int unsigned D = 1 << k;
    assign w_stg[k+1] = i_sh[k]
                      ? stage(w_stg[k], i_op, D)
                      : w_stg[k];
  end

  assign o_y = w_stg[4];

endmodule

// File: rtl/alu.sv
// 16-bit ALU with registered result and zero flag.
// One-cycle latency, one operation accepted per clock.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [2:0]       Alu_Opcode,
  input  logic             Shift,
  output logic [WIDTH-1:0] Result,
  output logic             Zero_Out
);

  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_shf;
  logic [WIDTH-1:0] w_next;
  logic             w_slt;

  alu_shifter #(
    .W(WIDTH)
  ) u_shifter (
    .i_a (Operand1),
    .i_sh(Operand2[3:0]),
    .i_op(Alu_Opcode),
    .o_y (w_shf)
  );

  assign w_slt = $signed(Operand1) < $signed(Operand2);

  always_comb begin
    w_alu = '0;
    case (Alu_Opcode)
      OP_ADD:   w_alu = Operand1 + Operand2;
      OP_SUB:   w_alu = Operand1 - Operand2;
      OP_AND:   w_alu = Operand1 & Operand2;
      OP_OR:    w_alu = Operand1 | Operand2;
      OP_XOR:   w_alu = Operand1 ^ Operand2;
      OP_NOT:   w_alu = ~Operand1;
      OP_SLT:   w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      OP_PASSB: w_alu = Operand2;
      default:  w_alu = '0;
    endcase
  end

  assign w_next = Shift ? w_shf : w_alu;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Result   <= '0;
      Zero_Out <= 1'b1;
    end else begin
      Result   <= w_next;
      Zero_Out <= (w_next == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 16-bit ALU.
// Each task drives one scenario and checks its own expectations.
module tb_alu;

  logic        Clk;
  logic        Reset;
  logic [15:0] Operand1;
  logic [15:0] Operand2;
  logic [2:0]  Alu_Opcode;
  logic        Shift;
  logic [15:0] Result;
  logic        Zero_Out;

  int errors = 0;
  int checks = 0;

  alu #(.WIDTH(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Alu_Opcode(Alu_Opcode),
    .Shift     (Shift),
    .Result    (Result),
    .Zero_Out  (Zero_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic drive(input logic sh, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    Shift      = sh;
    Alu_Opcode = op;
    Operand1   = a;
    Operand2   = b;
  endtask

  task automatic step(input logic sh, input logic [2:0] op,
                      input logic [15:0] a, input logic [15:0] b);
    drive(sh, op, a, b);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'b000, 16'h1111, 16'h2222);
    Reset = 1'b1;
    #1;
    checks++;
    if (Result !== 16'h0000 || Zero_Out !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: got %h/%b want 0000/1",
               Result, Zero_Out);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Result !== 16'h0000 || Zero_Out !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: got %h/%b want 0000/1",
               Result, Zero_Out);
    end
    Reset = 1'b0;
    step(1'b0, 3'b000, 16'h0003, 16'h0004);
    checks++;
    if (Result !== 16'h0007 || Zero_Out !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_add: got %h/%b want 0007/0",
               Result, Zero_Out);
    end
  endtask

  task automatic test_arith();
    logic [2:0]  op [3] = '{3'b000, 3'b001, 3'b001};
    logic [15:0] a  [3] = '{16'hFFFF, 16'h0000, 16'h1234};
    logic [15:0] b  [3] = '{16'h0001, 16'h0001, 16'h1234};
    logic [15:0] r  [3] = '{16'h0000, 16'hFFFF, 16'h0000};
    logic        z  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, op[i], a[i], b[i]);
      checks++;
      if (Result !== r[i] || Zero_Out !== z[i]) begin
        errors++;
        $display("FAIL arith[%0d]: got %h/%b want %h/%b",
                 i, Result, Zero_Out, r[i], z[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]  op [7] = '{3'b010, 3'b011, 3'b100, 3'b101,
                            3'b111, 3'b110, 3'b110};
    logic [15:0] a  [7] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0,
                            16'hF0F0, 16'h8000, 16'h0001};
    logic [15:0] b  [7] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                            16'hFF00, 16'h0001, 16'h8000};
    logic [15:0] r  [7] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F,
                            16'hFF00, 16'h0001, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, op[i], a[i], b[i]);
      checks++;
      if (Result !== r[i] || Zero_Out !== (r[i] == 16'h0)) begin
        errors++;
        $display("FAIL logic[%0d]: got %h/%b want %h/%b",
                 i, Result, Zero_Out, r[i], (r[i] == 16'h0));
      end
    end
  endtask

  task automatic test_shift();
    logic [2:0]  op [11] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                             3'b000, 3'b001, 3'b010, 3'b011, 3'b100,
                             3'b110};
    logic [15:0] b  [11] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001,
                             16'h0001, 16'h0010, 16'h0010, 16'h0010,
                             16'h0010, 16'h0010, 16'h0003};
    logic [15:0] r  [11] = '{16'h0002, 16'h4000, 16'hC000, 16'h0003,
                             16'hC000, 16'h8001, 16'h8001, 16'h8001,
                             16'h8001, 16'h8001, 16'h8001};
    for (int i = 0; i < 11; i++) begin
      step(1'b1, op[i], 16'h8001, b[i]);
      checks++;
      if (Result !== r[i] || Zero_Out !== 1'b0) begin
        errors++;
        $display("FAIL shift[%0d]: got %h/%b want %h/0",
                 i, Result, Zero_Out, r[i]);
      end
    end
    step(1'b1, 3'b010, 16'h8000, 16'h000F);
    checks++;
    if (Result !== 16'hFFFF) begin
      errors++;
      $display("FAIL sra_15: got %h want ffff", Result);
    end
    step(1'b1, 3'b100, 16'h1234, 16'h0008);
    checks++;
    if (Result !== 16'h3412) begin
      errors++;
      $display("FAIL ror_8: got %h want 3412", Result);
    end
  endtask

  task automatic test_back_to_back();
    logic        sh [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  op [8] = '{3'b000, 3'b001, 3'b100, 3'b011,
                            3'b101, 3'b111, 3'b000, 3'b100};
    logic [15:0] a  [8] = '{16'h0001, 16'h0010, 16'h00FF, 16'h1200,
                            16'h0000, 16'h0000, 16'h0001, 16'h0001};
    logic [15:0] b  [8] = '{16'h0002, 16'h0001, 16'h0F0F, 16'h0034,
                            16'h0000, 16'h5A5A, 16'h0004, 16'h0001};
    logic [15:0] r  [8] = '{16'h0003, 16'h000F, 16'h0FF0, 16'h1234,
                            16'hFFFF, 16'h5A5A, 16'h0010, 16'h8000};
    for (int i = 0; i < 8; i++) begin
      drive(sh[i], op[i], a[i], b[i]);
      if (i > 0) begin
        #3;
        checks++;
        if (Result !== r[i-1]) begin
          errors++;
          $display("FAIL b2b_hold[%0d]: got %h want %h",
                   i, Result, r[i-1]);
        end
      end
      @(posedge Clk);
      #1;
      checks++;
      if (Result !== r[i] || Zero_Out !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h/%b want %h/0",
                 i, Result, Zero_Out, r[i]);
      end
    end
  endtask

  task automatic test_midreset();
    step(1'b0, 3'b000, 16'h0003, 16'h0004);
    checks++;
    if (Result !== 16'h0007) begin
      errors++;
      $display("FAIL mid_pre: got %h want 0007", Result);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (Result !== 16'h0000 || Zero_Out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got %h/%b want 0000/1",
               Result, Zero_Out);
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    step(1'b0, 3'b011, 16'h0000, 16'h0000);
    checks++;
    if (Result !== 16'h0000 || Zero_Out !== 1'b1) begin
      errors++;
      $display("FAIL mid_or_zero: got %h/%b want 0000/1",
               Result, Zero_Out);
    end
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b0, 3'b000, 16'h0000, 16'h0000);
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_back_to_back();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
